// File: rtl/aes_pkg.sv
// Shared AES constants, byte/state types and the InvShiftRows source-index function.
// Pure definitions; no logic of its own.
package aes_pkg;

    localparam int AES_NB          = 4;
    localparam int AES_STATE_BYTES = 16;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [127:0] aes_state_t;

    // Result byte 4c+r comes from input byte 4*((c-r) mod 4)+r; the 2-bit subtract wraps mod 4.
    function automatic logic [3:0] isr_src_idx(input logic [3:0] idx);
        logic [1:0] col;
        logic [1:0] row;
        logic [1:0] src_col;
        col     = idx[3:2];
        row     = idx[1:0];
        src_col = col - row;
        return {src_col, row};
    endfunction

endpackage

// File: rtl/isr_index_map.sv
// Maps a column-major result index to the input byte it is read from after InvShiftRows.
// Purely combinational, zero latency, no flow control.
module isr_index_map
    import aes_pkg::*;
(
    input  logic [3:0] idx,
    output logic [3:0] src_idx
);

    assign src_idx = isr_src_idx(idx);

endmodule

// File: rtl/inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows over two ping-pong 16-byte banks; first result one cycle after byte 15.
// Holds off upstream only when both banks are full; output held steady while out_ready is low.
module inv_shift_rows_stream
    import aes_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_byte,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_byte,
    output logic       out_last
);

    aes_byte_t  bank [2][AES_STATE_BYTES];
    logic [1:0] full;
    logic       wr_sel;
    logic       rd_sel;
    logic [3:0] wr_cnt;
    logic [3:0] rd_cnt;
    logic [3:0] src_idx;
    logic       in_fire;
    logic       out_fire;
    logic [1:0] full_set;
    logic [1:0] full_clr;

    isr_index_map u_index_map (
        .idx     (rd_cnt),
        .src_idx (src_idx)
    );

    // All outputs are decoded from registers only, so no in_* / out_ready feed-through.
    assign in_ready  = !full[wr_sel];
    assign out_valid = full[rd_sel];
    assign out_byte  = out_valid ? bank[rd_sel][src_idx] : 8'h00;
    assign out_last  = out_valid && (rd_cnt == 4'hF);

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // Set always hits an empty bank and clear a full one, so both can land in one cycle.
    assign full_set = (in_fire && (wr_cnt == 4'hF))  ? (2'b01 << wr_sel) : 2'b00;
    assign full_clr = (out_fire && (rd_cnt == 4'hF)) ? (2'b01 << rd_sel) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < AES_STATE_BYTES; i++) begin
                    bank[b][i] <= 8'h00;
                end
            end
        end else if (in_fire) begin
            bank[wr_sel][wr_cnt] <= in_byte;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full   <= 2'b00;
            wr_sel <= 1'b0;
            rd_sel <= 1'b0;
            wr_cnt <= 4'h0;
            rd_cnt <= 4'h0;
        end else begin
            full <= (full | full_set) & ~full_clr;
            if (in_fire) begin
                wr_cnt <= wr_cnt + 4'h1;
                if (wr_cnt == 4'hF) begin
                    wr_sel <= !wr_sel;
                end
            end
            if (out_fire) begin
                rd_cnt <= rd_cnt + 4'h1;
                if (rd_cnt == 4'hF) begin
                    rd_sel <= !rd_sel;
                end
            end
        end
    end

    out_hold_a: assert property (@(posedge clk) disable iff (rst)
        out_valid && !out_ready |=> $stable(out_byte));

    no_overfill_a: assert property (@(posedge clk) disable iff (rst)
        !(full[0] && full[1] && in_ready));

endmodule
